// File: rtl/rf_wb_arbiter.sv
// Round-robin writeback arbiter (EXU vs LSU) with a registered register-file write port
// and a per-register pending-write scoreboard. Optional macro: RF_WB_ARBITER_EARLY_RELEASE_EN.
module rf_wb_arbiter #(
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  a_valid,
  output logic                  a_ready,
  input  logic [ADDR_WIDTH-1:0] a_addr,
  input  logic [DATA_WIDTH-1:0] a_data,
  input  logic                  b_valid,
  output logic                  b_ready,
  input  logic [ADDR_WIDTH-1:0] b_addr,
  input  logic [DATA_WIDTH-1:0] b_data,
  output logic                  rf_wen,
  output logic [ADDR_WIDTH-1:0] rf_waddr,
  output logic [DATA_WIDTH-1:0] rf_wdata,
  input  logic                  iss_valid,
  input  logic [ADDR_WIDTH-1:0] iss_addr,
  input  logic [ADDR_WIDTH-1:0] chk_addr1,
  input  logic [ADDR_WIDTH-1:0] chk_addr2,
  output logic                  hazard
);

  localparam int NumRegs = 1 << ADDR_WIDTH;

  logic                  last_b;
  logic                  grant_a;
  logic                  grant_b;
  logic                  acc_wr;
  logic [ADDR_WIDTH-1:0] acc_addr;
  logic [DATA_WIDTH-1:0] acc_data;
  logic [NumRegs-1:0]    busy;
  logic [NumRegs-1:0]    busy_nxt;
  logic                  src1_busy;
  logic                  src2_busy;

  // last_b set means B won most recently, so A takes the next contention.
  always_comb begin
    grant_a  = rst_n & a_valid & (~b_valid | last_b);
    grant_b  = rst_n & b_valid & (~a_valid | ~last_b);
    acc_addr = grant_a ? a_addr : b_addr;
    acc_data = grant_a ? a_data : b_data;
    acc_wr   = (grant_a | grant_b) & (acc_addr != '0);
  end

  assign a_ready = grant_a;
  assign b_ready = grant_b;

  // Clear is applied before set so a new producer issued on the commit edge keeps the bit.
  always_comb begin
    busy_nxt = busy;
    if (rf_wen) busy_nxt[rf_waddr] = 1'b0;
    if (iss_valid && (iss_addr != '0)) busy_nxt[iss_addr] = 1'b1;
    busy_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_b   <= 1'b1;
      rf_wen   <= 1'b0;
      rf_waddr <= '0;
      rf_wdata <= '0;
      busy     <= '0;
    end else begin
      if (grant_a || grant_b) last_b <= grant_b;
      rf_wen <= acc_wr;
      if (acc_wr) begin
        rf_waddr <= acc_addr;
        rf_wdata <= acc_data;
      end
      busy <= busy_nxt;
    end
  end

`ifdef RF_WB_ARBITER_EARLY_RELEASE_EN
  // A register committing this cycle is forwarded by the register file, so it is not a hazard.
  always_comb begin
    src1_busy = busy[chk_addr1] & ~(rf_wen & (rf_waddr == chk_addr1));
    src2_busy = busy[chk_addr2] & ~(rf_wen & (rf_waddr == chk_addr2));
  end
`else
  always_comb begin
    src1_busy = busy[chk_addr1];
    src2_busy = busy[chk_addr2];
  end
`endif

  assign hazard = rst_n & (src1_busy | src2_busy);

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Bench for rf_wb_arbiter: directed stimulus, per-cycle reference model plus literal checks.
module tb_rf_wb_arbiter;

`ifdef RF_WB_ARBITER_EARLY_RELEASE_EN
  localparam bit Early = 1'b1;
`else
  localparam bit Early = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        a_valid, b_valid, iss_valid;
  logic        a_ready, b_ready, rf_wen, hazard;
  logic [4:0]  a_addr, b_addr, rf_waddr, iss_addr, chk_addr1, chk_addr2;
  logic [31:0] a_data, b_data, rf_wdata;

  int total = 0;
  int bad   = 0;

  rf_wb_arbiter #(.ADDR_WIDTH(5), .DATA_WIDTH(32)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .a_valid  (a_valid),
    .a_ready  (a_ready),
    .a_addr   (a_addr),
    .a_data   (a_data),
    .b_valid  (b_valid),
    .b_ready  (b_ready),
    .b_addr   (b_addr),
    .b_data   (b_data),
    .rf_wen   (rf_wen),
    .rf_waddr (rf_waddr),
    .rf_wdata (rf_wdata),
    .iss_valid(iss_valid),
    .iss_addr (iss_addr),
    .chk_addr1(chk_addr1),
    .chk_addr2(chk_addr2),
    .hazard   (hazard)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s @%0t: got %0h, expected %0h", name, $time, act, exp);
    end
  endtask

  // Reference model: who won last, the pending write, and the set of registers awaiting data.
  int          m_last;  // 0 = A won last, 1 = B won last
  bit          m_wen;
  logic [4:0]  m_waddr;
  logic [31:0] m_wdata;
  bit          m_busy[32];

  task automatic model_reset();
    m_last = 1; m_wen = 0; m_waddr = '0; m_wdata = '0;
    foreach (m_busy[i]) m_busy[i] = 0;
  endtask

  function automatic bit pending(input logic [4:0] r);
    if (r == 0 || !m_busy[r]) return 0;
    if (Early && m_wen && m_waddr == r) return 0;
    return 1;
  endfunction

  initial model_reset();

  always begin
    int          winner;  // -1 none, 0 A, 1 B
    bit          n_wen;
    logic [4:0]  n_waddr, w_addr;
    logic [31:0] n_wdata, w_data;
    bit          n_busy[32];
    @(negedge clk);
    if (!rst_n) model_reset();
    if (!rst_n) winner = -1;
    else if (a_valid && b_valid) winner = (m_last == 1) ? 0 : 1;
    else if (a_valid) winner = 0;
    else if (b_valid) winner = 1;
    else winner = -1;
    chk("m_a_ready", a_ready, winner == 0);
    chk("m_b_ready", b_ready, winner == 1);
    chk("m_hazard", hazard, rst_n && (pending(chk_addr1) || pending(chk_addr2)));
    chk("m_rf_wen", rf_wen, m_wen);
    chk("m_rf_waddr", rf_waddr, m_waddr);
    chk("m_rf_wdata", rf_wdata, m_wdata);
    n_waddr = m_waddr; n_wdata = m_wdata; n_wen = 0;
    w_addr = (winner == 0) ? a_addr : b_addr;
    w_data = (winner == 0) ? a_data : b_data;
    if (winner >= 0 && w_addr != 0) begin
      n_wen = 1; n_waddr = w_addr; n_wdata = w_data;
    end
    n_busy = m_busy;
    if (m_wen) n_busy[m_waddr] = 0;
    if (iss_valid && iss_addr != 0) n_busy[iss_addr] = 1;
    @(posedge clk);
    if (rst_n) begin
      if (winner >= 0) m_last = winner;
      m_wen = n_wen; m_waddr = n_waddr; m_wdata = n_wdata; m_busy = n_busy;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    bit          exp_a[4]  = '{1, 0, 1, 0};
    logic [4:0]  exp_wa[4] = '{5'd1, 5'd2, 5'd1, 5'd2};
    rst_n = 0; a_valid = 1; b_valid = 0; iss_valid = 0;
    a_addr = 5'd3; b_addr = 0; iss_addr = 0; chk_addr1 = 0; chk_addr2 = 0;
    a_data = 32'h55; b_data = 0;
    tick(); tick();
    @(negedge clk);
    chk("rst_a_ready", a_ready, 0);
    chk("rst_rf_wen", rf_wen, 0);
    chk("rst_waddr", rf_waddr, 0);
    chk("rst_wdata", rf_wdata, 0);
    chk("rst_hazard", hazard, 0);
    tick(); rst_n = 1; a_valid = 0;

    // Single A write to r5
    tick(); a_valid = 1; a_addr = 5'd5; a_data = 32'h1234;
    @(negedge clk); chk("a5_ready", a_ready, 1);
    tick(); a_valid = 0;
    @(negedge clk);
    chk("a5_wen", rf_wen, 1); chk("a5_waddr", rf_waddr, 5); chk("a5_wdata", rf_wdata, 32'h1234);
    tick();
    @(negedge clk); chk("a5_wen_drop", rf_wen, 0); chk("a5_waddr_hold", rf_waddr, 5);

    // Contention straight after reset: A,B,A,B
    tick(); rst_n = 0;
    tick(); rst_n = 1;
    a_valid = 1; a_addr = 5'd1; a_data = 32'hA1; b_valid = 1; b_addr = 5'd2; b_data = 32'hB2;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("rr_a_ready", a_ready, exp_a[i]);
      chk("rr_b_ready", b_ready, !exp_a[i]);
      if (i > 0) chk("rr_waddr", rf_waddr, exp_wa[i-1]);
      tick();
      if (i == 3) begin a_valid = 0; b_valid = 0; end
    end
    @(negedge clk); chk("rr_waddr_last", rf_waddr, 2); chk("rr_wdata_last", rf_wdata, 32'hB2);

    // Scoreboard on r7
    tick(); iss_valid = 1; iss_addr = 5'd7; chk_addr1 = 5'd7;
    @(negedge clk); chk("r7_hz_pre", hazard, 0);
    tick(); iss_valid = 0;
    @(negedge clk); chk("r7_hz_set", hazard, 1);
    tick(); a_valid = 1; a_addr = 5'd7; a_data = 32'h77;
    @(negedge clk); chk("r7_hz_acc", hazard, 1);
    tick(); a_valid = 0;
    @(negedge clk); chk("r7_commit", rf_wen, 1); chk("r7_hz_commit", hazard, !Early);
    tick();
    @(negedge clk); chk("r7_hz_after", hazard, 0);

    // Set and clear of r9 on the same edge: set wins
    tick(); iss_valid = 1; iss_addr = 5'd9; chk_addr1 = 0; chk_addr2 = 5'd9;
    tick(); iss_valid = 0; a_valid = 1; a_addr = 5'd9; a_data = 32'h99;
    @(negedge clk); chk("r9_hz_acc", hazard, 1);
    tick(); a_valid = 0; iss_valid = 1;
    @(negedge clk); chk("r9_commit", rf_wen, 1); chk("r9_hz_commit", hazard, !Early);
    tick(); iss_valid = 0;
    @(negedge clk); chk("r9_hz_kept", hazard, 1);

    // Write to r0 is consumed without a write pulse; r0 is never pending
    tick(); a_valid = 1; a_addr = 0; a_data = 32'hFFFF; iss_valid = 1; iss_addr = 0;
    chk_addr1 = 0; chk_addr2 = 0;
    @(negedge clk); chk("r0_ready", a_ready, 1); chk("r0_hz", hazard, 0);
    tick(); a_valid = 0; iss_valid = 0;
    @(negedge clk); chk("r0_wen", rf_wen, 0); chk("r0_hz_after", hazard, 0);

    // Lone B wins although A won last; idle cycles keep the pointer
    tick(); b_valid = 1; b_addr = 5'd3; b_data = 32'h33;
    @(negedge clk); chk("b_only_ready", b_ready, 1); chk("b_only_a", a_ready, 0);
    tick(); b_valid = 0;
    tick(); tick();
    a_valid = 1; a_addr = 5'd4; a_data = 32'h44; b_valid = 1; b_addr = 5'd6; b_data = 32'h66;
    @(negedge clk); chk("hold_a_first", a_ready, 1);
    tick();
    @(negedge clk); chk("hold_b_next", b_ready, 1); chk("hold_wdata", rf_wdata, 32'h44);
    tick(); a_valid = 0; b_valid = 0;

    // Reset right after an acceptance kills the pending write
    tick(); a_valid = 1; a_addr = 5'd10; a_data = 32'hAA; iss_valid = 1; iss_addr = 5'd11;
    tick(); a_valid = 0; iss_valid = 0; chk_addr1 = 5'd11; chk_addr2 = 5'd9;
    chk("mid_wen_pre", rf_wen, 1);
    rst_n = 0;
    #1;
    chk("mid_wen_rst", rf_wen, 0);
    chk("mid_hz_rst", hazard, 0);
    tick(); tick(); rst_n = 1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("post_rst_wen", rf_wen, 0);
      chk("post_rst_hz", hazard, 0);
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
